// File: rtl/upsample_pkg.sv
// Shared definitions for the zero-stuffing upsampler: FSM encoding and ratio-port width.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package upsample_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Width needed to hold every ratio value 0..max_ratio.
    function automatic int f_ratio_w(input int max_ratio);
        return $clog2(max_ratio + 1);
    endfunction

endpackage

// File: rtl/upsample_ctrl_buf.sv
// One-entry valid/ready input buffer for the upsampler.
// Latency: one cycle from accepted input to o_full/o_data.
// Backpressure: o_ready low when full unless the entry is being consumed this cycle.
module upsample_ctrl_buf #(
    parameter int gp_data_width = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_an,
    input  logic                     i_ena,
    input  logic                     i_valid,
    input  logic [gp_data_width-1:0] i_data,
    output logic                     o_ready,
    input  logic                     i_consume,
    output logic                     o_full,
    output logic [gp_data_width-1:0] o_data
);

    logic                     full;
    logic [gp_data_width-1:0] data;
    logic                     pop;
    logic                     push;

    // Freeing the entry in the same cycle lets a new sample slide in without a bubble.
    assign pop     = i_ena & i_consume & full;
    assign o_ready = ~full | pop;
    assign push    = i_ena & i_valid & o_ready;

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            if (push) begin
                data <= i_data;
                full <= 1'b1;
            end else if (pop) begin
                full <= 1'b0;
            end
        end
    end

    assign o_full = full;
    assign o_data = data;

endmodule

// File: rtl/upsample_ctrl.sv
// Zero-stuffing upsampler controller: emits R_eff high-rate slots per input sample; UPSAMPLE_CTRL_ZOH_EN selects zero-order hold fill.
// Latency: outputs registered, one i_ena cycle after each slot decision.
// Backpressure: none on the output side; input throttled via o_ready from the one-entry buffer.
module upsample_ctrl import upsample_pkg::*; #(
    parameter  int gp_data_width = 8,
    parameter  int gp_max_ratio  = 16,
    localparam int c_ratio_w     = f_ratio_w(gp_max_ratio)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_an,
    input  logic                     i_ena,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic [c_ratio_w-1:0]     i_ratio,
    input  logic [c_ratio_w-1:0]     i_phase,
    input  logic                     i_valid,
    input  logic [gp_data_width-1:0] i_data,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [gp_data_width-1:0] o_data,
    output logic                     o_load,
    output logic                     o_frame,
    output logic                     o_underrun
);

    function automatic logic [c_ratio_w-1:0] f_eff(input logic [c_ratio_w-1:0] r);
        if (r == '0)
            return c_ratio_w'(1);
        if (int'(r) > gp_max_ratio)
            return c_ratio_w'(gp_max_ratio);
        return r;
    endfunction

    state_t                   state;
    logic [c_ratio_w-1:0]     r_eff;
    logic [c_ratio_w-1:0]     slot_cnt;
    logic [c_ratio_w-1:0]     align_cnt;
    logic                     stop_pend;

    logic                     buf_full;
    logic [gp_data_width-1:0] buf_data;
    logic                     load_slot;
    logic                     last_slot;
    logic [c_ratio_w-1:0]     ratio_next;
    logic [c_ratio_w-1:0]     phase_next;
    logic [gp_data_width-1:0] fill;

    assign ratio_next = f_eff(i_ratio);
    assign phase_next = i_phase % ratio_next;
    assign load_slot  = (state == ST_RUN) && (slot_cnt == '0);
    assign last_slot  = (slot_cnt == r_eff - c_ratio_w'(1));

    upsample_ctrl_buf #(
        .gp_data_width (gp_data_width)
    ) u_buf (
        .i_clk     (i_clk),
        .i_rst_an  (i_rst_an),
        .i_ena     (i_ena),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .i_consume (load_slot),
        .o_full    (buf_full),
        .o_data    (buf_data)
    );

`ifdef UPSAMPLE_CTRL_ZOH_EN
    logic [gp_data_width-1:0] hold_q;

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an)
            hold_q <= '0;
        else if (i_ena && load_slot && buf_full)
            hold_q <= buf_data;
    end

    assign fill = hold_q;
`else
    assign fill = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state      <= ST_IDLE;
            r_eff      <= c_ratio_w'(1);
            slot_cnt   <= '0;
            align_cnt  <= '0;
            stop_pend  <= 1'b0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_load     <= 1'b0;
            o_frame    <= 1'b0;
            o_underrun <= 1'b0;
        end else if (i_ena) begin
            o_load  <= 1'b0;
            o_frame <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_valid   <= 1'b0;
                    o_data    <= '0;
                    stop_pend <= 1'b0;
                    // A simultaneous stop keeps the block parked.
                    if (i_start && !i_stop) begin
                        r_eff      <= ratio_next;
                        slot_cnt   <= '0;
                        o_underrun <= 1'b0;
                        if (phase_next == '0) begin
                            state <= ST_RUN;
                        end else begin
                            align_cnt <= phase_next;
                            state     <= ST_ALIGN;
                        end
                    end
                end
                ST_ALIGN: begin
                    if (i_stop) begin
                        state   <= ST_IDLE;
                        o_valid <= 1'b0;
                        o_data  <= '0;
                    end else begin
                        o_valid   <= 1'b1;
                        o_data    <= fill;
                        align_cnt <= align_cnt - c_ratio_w'(1);
                        if (align_cnt == c_ratio_w'(1)) begin
                            state    <= ST_RUN;
                            slot_cnt <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    o_valid <= 1'b1;
                    if (load_slot) begin
                        o_load  <= 1'b1;
                        o_frame <= 1'b1;
                        if (buf_full) begin
                            o_data <= buf_data;
                        end else begin
                            o_data     <= fill;
                            o_underrun <= 1'b1;
                        end
                    end else begin
                        o_data <= fill;
                    end
                    // Ratio changes and stop requests only land on frame boundaries.
                    if (last_slot) begin
                        slot_cnt <= '0;
                        r_eff    <= ratio_next;
                        if (stop_pend || i_stop) begin
                            state     <= ST_IDLE;
                            stop_pend <= 1'b0;
                        end
                    end else begin
                        slot_cnt <= slot_cnt + c_ratio_w'(1);
                        if (i_stop)
                            stop_pend <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_upsample_ctrl.sv
// Bench for upsample_ctrl: frame-level reference model compared every cycle, plus literal stream expectations.
// Latency: n/a.
// Backpressure: input feeder honours o_ready.
module tb_upsample_ctrl;

    localparam int W  = 8;
    localparam int MR = 16;
    localparam int RW = 5;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena   = 1'b1;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic [RW-1:0] ratio = '0;
    logic [RW-1:0] phase = '0;
    logic          valid = 1'b0;
    logic [W-1:0]  din   = '0;
    logic          ready, ovalid, load, frame, unr;
    logic [W-1:0]  dout;

    always #5 clk = ~clk;

    upsample_ctrl dut (
        .i_clk      (clk),
        .i_rst_an   (rst_n),
        .i_ena      (ena),
        .i_start    (start),
        .i_stop     (stop),
        .i_ratio    (ratio),
        .i_phase    (phase),
        .i_valid    (valid),
        .i_data     (din),
        .o_ready    (ready),
        .o_valid    (ovalid),
        .o_data     (dout),
        .o_load     (load),
        .o_frame    (frame),
        .o_underrun (unr)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Input feeder: presents queued samples, drops each one once accepted.
    int feed_q[$];
    always @(posedge clk)
        if (rst_n && ena && valid && ready && feed_q.size() > 0) void'(feed_q.pop_front());
    always @(negedge clk) begin
        valid = (feed_q.size() > 0);
        din   = valid ? W'(feed_q[0]) : '0;
    end

    // Reference model: a running frame of m_len slots, m_zeros leading fill slots, one-sample buffer.
    bit m_on = 0, m_stop = 0, m_unr = 0, m_stepped = 0;
    int m_zeros = 0, m_pos = 0, m_len = 1;
    int m_buf[$];
    int e_valid = 0, e_data = 0, e_load = 0, e_frame = 0;

    function automatic int eff(input int r);
        return (r == 0) ? 1 : (r > MR) ? MR : r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_on = 0; m_stop = 0; m_unr = 0; m_stepped = 0;
            m_zeros = 0; m_pos = 0; m_len = 1; m_buf = {};
            e_valid = 0; e_data = 0; e_load = 0; e_frame = 0;
        end else begin
            m_stepped = ena;
            if (ena) begin
                bit take, push;
                int smp;
                smp  = int'(din);
                take = m_on && m_zeros == 0 && m_pos == 0 && m_buf.size() > 0;
                push = valid && (m_buf.size() == 0 || take);
                e_load = 0; e_frame = 0;
                if (!m_on) begin
                    e_valid = 0; e_data = 0; m_stop = 0;
                    if (start && !stop) begin
                        m_len = eff(int'(ratio)); m_zeros = int'(phase) % m_len;
                        m_pos = 0; m_on = 1; m_unr = 0;
                    end
                end else if (m_zeros > 0) begin
                    if (stop) begin m_on = 0; e_valid = 0; e_data = 0; end
                    else begin e_valid = 1; e_data = 0; m_zeros--; end
                end else begin
                    e_valid = 1; e_data = 0;
                    if (m_pos == 0) begin
                        e_load = 1; e_frame = 1;
                        if (m_buf.size() > 0) e_data = m_buf.pop_front();
                        else m_unr = 1;
                    end
                    if (stop) m_stop = 1;
                    m_pos++;
                    if (m_pos == m_len) begin
                        m_pos = 0; m_len = eff(int'(ratio));
                        if (m_stop) begin m_on = 0; m_stop = 0; end
                    end
                end
                if (push) m_buf.push_back(smp);
            end
        end
    end

    // Per-cycle compare and capture of the emitted stream.
    int cap_d[$];
    int cap_f[$];
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("o_valid", int'(ovalid), e_valid);
            check("o_ready", int'(ready),
                  (m_buf.size() == 0 || (ena && m_on && m_zeros == 0 && m_pos == 0)) ? 1 : 0);
            check("o_underrun", int'(unr), int'(m_unr));
            if (e_valid != 0) begin
                check("o_data", int'(dout), e_data);
                check("o_load", int'(load), e_load);
                check("o_frame", int'(frame), e_frame);
            end
            if (m_stepped && ovalid) begin
                cap_d.push_back(int'(dout));
                cap_f.push_back(int'(frame));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go(input int r, input int ph);
        cap_d = {}; cap_f = {};
        ratio = RW'(r); phase = RW'(ph); start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    task automatic chk_stream(input string nm, input int ed[$], input int ef[$]);
        check({nm, " length"}, (cap_d.size() >= ed.size()) ? 1 : 0, 1);
        foreach (ed[i])
            if (i < cap_d.size()) begin
                check($sformatf("%s data[%0d]", nm, i), cap_d[i], ed[i]);
                check($sformatf("%s frame[%0d]", nm, i), cap_f[i], ef[i]);
            end
    endtask

    initial begin
        int ed[$];
        int ef[$];
        #1;
        check("reset o_ready", int'(ready), 1);
        check("reset o_valid", int'(ovalid), 0);
        check("reset o_data", int'(dout), 0);
        check("reset o_load", int'(load), 0);
        check("reset o_frame", int'(frame), 0);
        check("reset o_underrun", int'(unr), 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // R=4, phase 0, three samples; stop during slot 1 of the third frame.
        feed_q = {10, 20, 30};
        step(2);
        go(4, 0);
        step(9);
        pulse_stop();
        step(4);
        ed = {10, 0, 0, 0, 20, 0, 0, 0, 30, 0, 0, 0};
        ef = {1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
        chk_stream("r4p0", ed, ef);
        check("r4p0 exact length", cap_d.size(), 12);
        check("r4p0 idle after stop", int'(ovalid), 0);
        check("r4p0 no underrun", int'(unr), 0);

        // R=4, phase 2; second load slot finds the buffer empty.
        feed_q = {10};
        step(2);
        go(4, 2);
        step(7);
        ed = {0, 0, 10, 0, 0, 0, 0};
        ef = {0, 0, 1, 0, 0, 0, 1};
        chk_stream("r4p2", ed, ef);
        check("underrun set", int'(unr), 1);
        pulse_stop();
        step(5);
        check("underrun sticky in idle", int'(unr), 1);

        // Stop seen during alignment returns to idle at once.
        go(4, 3);
        check("start clears underrun", int'(unr), 0);
        step(1);
        check("align slot valid", int'(ovalid), 1);
        pulse_stop();
        check("align stop immediate", int'(ovalid), 0);
        step(2);

        // Ratio change mid-frame only affects the next frame.
        feed_q = {1, 2, 3};
        step(2);
        go(4, 0);
        step(2);
        ratio = RW'(2);
        step(6);
        ed = {1, 0, 0, 0, 2, 0, 3, 0};
        ef = {1, 0, 0, 0, 1, 0, 1, 0};
        chk_stream("ratio 4->2", ed, ef);
        pulse_stop();
        step(4);

        // Ratio 0 is pass-through; phase 3 folds to 0.
        feed_q = {5, 6, 7};
        step(2);
        go(0, 3);
        step(3);
        ed = {5, 6, 7};
        ef = {1, 1, 1};
        chk_stream("pass-through", ed, ef);
        check("pass-through no underrun", int'(unr), 0);
        pulse_stop();
        step(3);

        // Ratio 31 clamps to 16-slot frames; a clock-enable gap mid-frame.
        feed_q = {1, 2};
        step(2);
        go(31, 0);
        step(3);
        ena = 1'b0;
        step(3);
        ena = 1'b1;
        step(14);
        ed = {}; ef = {};
        for (int i = 0; i < 17; i++) begin
            ed.push_back(i == 0 ? 1 : (i == 16 ? 2 : 0));
            ef.push_back((i == 0 || i == 16) ? 1 : 0);
        end
        chk_stream("clamp 16", ed, ef);
        pulse_stop();
        step(18);

        // Reset mid-frame aborts; restart requires i_start, and stop beats start.
        feed_q = {9};
        step(2);
        go(4, 0);
        step(3);
        rst_n = 1'b0;
        #1;
        check("midframe reset o_valid", int'(ovalid), 0);
        check("midframe reset o_data", int'(dout), 0);
        check("midframe reset o_load", int'(load), 0);
        check("midframe reset o_frame", int'(frame), 0);
        check("midframe reset o_ready", int'(ready), 1);
        step(2);
        rst_n = 1'b1;
        step(5);
        check("no output without start", int'(ovalid), 0);
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        step(3);
        check("stop wins over start", int'(ovalid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
